memofs_loop_stage: RTL and testbench
====================================

MEMOFS_LOOP_STAGE -- requirements
Module: memofs_loop_stage

Interface
REQ-001 Parameter N_CFG, default TauCfg::N_ICFG, number of configuration slots iterated per point.
REQ-002 Parameter CNT_BW, default TauCfg::GLOBAL_ADDR_BW, width of each loop bound and counter.
REQ-003 Localparams SHALL be DIM = TauCfg::DIM and CFG_BW = $clog2(N_CFG+1).
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 src_rdy  in  1  block command valid.
REQ-008 src_ack  out  1  block command accepted.
REQ-009 i_bound  in  CNT_BW x [DIM]  per-dimension trip count; index DIM-1 is innermost.
REQ-010 i_ncfg  in  CFG_BW  number of configs, legal 1..N_CFG.
REQ-011 dst_rdy  out  1  flag word valid.
REQ-012 dst_ack  in  1  flag word consumed; high only while dst_rdy is high.
REQ-013 o_reset_flag  out  [DIM]  per-dimension counter reset.
REQ-014 o_add_flag  out  [DIM]  per-dimension counter increment.
REQ-015 o_id  out  CFG_BW  config slot of this word.
REQ-016 o_islast  out  1  final word of the block.

Function
REQ-017 The block SHALL have states IDLE and RUN; src_ack SHALL equal src_rdy in IDLE and 0 in RUN.
REQ-018 On src_ack with all bounds nonzero and i_ncfg nonzero, it SHALL latch bounds and i_ncfg, clear point counters, set o_id=0, o_reset_flag=all ones, o_add_flag=0, and enter RUN; dst_rdy SHALL rise the next cycle.
REQ-019 On src_ack with any bound zero or i_ncfg zero, it SHALL stay IDLE and emit no words.
REQ-020 In RUN, dst_rdy SHALL be 1 and all outputs registered and stable until dst_ack.
REQ-021 For each ND point, the block SHALL emit i_ncfg words with o_id 0..i_ncfg-1 in order and identical flags.
REQ-022 On dst_ack with o_id < i_ncfg-1, o_id SHALL increment; flags and counters SHALL hold.
REQ-023 On dst_ack with o_id = i_ncfg-1 and not last point: d = highest index whose counter < bound-1; counter[d]++, counters above d cleared, o_add_flag = one-hot d, o_reset_flag[k]=1 exactly for k>d, o_id=0.
REQ-024 o_islast SHALL be 1 only when every counter equals bound-1 and o_id = i_ncfg-1.
REQ-025 On dst_ack of the o_islast word, the block SHALL return to IDLE and deassert dst_rdy the next cycle; src_ack SHALL not assert in that same cycle.
REQ-026 Bound of 1 in any dimension SHALL never produce add_flag in that dimension.
REQ-027 Total words per block SHALL equal i_ncfg x product of bounds.
REQ-028 Changes on i_bound or i_ncfg while in RUN SHALL have no effect.

Reset
REQ-029 Reset SHALL force IDLE, dst_rdy=0, src_ack=0, counters=0, o_reset_flag=0, o_add_flag=0, o_id=0, o_islast=0.
REQ-030 Reset asserted mid-block SHALL abandon the block; no further words SHALL be emitted after deassertion until a new command.

Structure
REQ-031 DIM, N_ICFG and GLOBAL_ADDR_BW SHALL come from package TauCfg; no new package types are needed.
REQ-032 Carry detection (counter==bound-1 per dim, select d, build flags) SHALL be one combinational sub-module NDLoopCarry.
REQ-033 Handshake and state SHALL be in this module; no skid buffer.

Verification (DIM=3, N_CFG=4)
REQ-034 Bounds {1,1,1}, ncfg=1 -> single word reset=111, add=000, id=0, islast=1; IDLE next cycle.
REQ-035 Bounds {1,2,3}, ncfg=2 -> 12 words; 3rd word id=0 add=001 reset=000; 7th word id=0 add=010 reset=001; 12th islast=1.
REQ-036 Bounds {2,1,2}, ncfg=1, dst_ack held 0 for 5 cycles at word 2 -> outputs stable, then add=100 reset=011 at word 3.
REQ-037 Bounds {0,4,4}, ncfg=3 -> src_ack pulses, no dst_rdy, state IDLE.
REQ-038 i_rst asserted after word 3 of bounds {2,2,2} ncfg=1 -> dst_rdy=0 immediately, all outputs zero; new command {1,1,2} yields 2 words.
REQ-039 Back-to-back commands with src_rdy held high -> second src_ack no earlier than the cycle after the islast dst_ack; word counts match REQ-027.

Source files
------------

// File: rtl/memofs_loop_stage_pkg.sv
// Shared loop-engine configuration: dimensionality, config slot count, address width.
package TauCfg;

    localparam int unsigned DIM            = 3;
    localparam int unsigned N_ICFG         = 4;
    localparam int unsigned GLOBAL_ADDR_BW = 8;

endpackage : TauCfg

// File: rtl/memofs_loop_stage_carry.sv
// Combinational carry logic for an N-dimensional loop nest.
// Finds the innermost-first dimension that can still advance, builds the
// add/reset flag words and the counter values for the next point.
module NDLoopCarry #(
    parameter int unsigned DIM    = TauCfg::DIM,
    parameter int unsigned CNT_BW = TauCfg::GLOBAL_ADDR_BW
) (
    input  logic [CNT_BW-1:0] bound_i      [DIM],
    input  logic [CNT_BW-1:0] cnt_i        [DIM],
    output logic              all_last_o,
    output logic [0:DIM-1]    add_flag_o,
    output logic [0:DIM-1]    reset_flag_o,
    output logic [CNT_BW-1:0] cnt_nxt_o    [DIM],
    output logic              nxt_all_last_o
);

    logic [0:DIM-1] at_last;
    logic           hit;

    // Per-dimension "counter sits on its final value" detection.
    always_comb begin
        at_last = '0;
        for (int k = 0; k < int'(DIM); k++) begin
            at_last[k] = (cnt_i[k] == (bound_i[k] - CNT_BW'(1)));
        end
        all_last_o = &at_last;
    end

    // Scan from innermost outward; the first non-final dimension advances,
    // every dimension inside it is cleared and flagged for reset.
    always_comb begin
        hit          = 1'b0;
        add_flag_o   = '0;
        reset_flag_o = '0;
        for (int k = 0; k < int'(DIM); k++) begin
            cnt_nxt_o[k] = cnt_i[k];
        end
        for (int k = int'(DIM) - 1; k >= 0; k--) begin
            if (!hit) begin
                if (!at_last[k]) begin
                    add_flag_o[k] = 1'b1;
                    cnt_nxt_o[k]  = cnt_i[k] + CNT_BW'(1);
                    hit           = 1'b1;
                end else begin
                    reset_flag_o[k] = 1'b1;
                    cnt_nxt_o[k]    = '0;
                end
            end
        end
    end

    // Whether the point after this carry is the final point of the nest.
    always_comb begin
        nxt_all_last_o = 1'b1;
        for (int k = 0; k < int'(DIM); k++) begin
            if (cnt_nxt_o[k] != (bound_i[k] - CNT_BW'(1))) begin
                nxt_all_last_o = 1'b0;
            end
        end
    end

endmodule : NDLoopCarry

// File: rtl/memofs_loop_stage.sv
// Loop-nest flag generator: accepts a block command (per-dimension trip
// counts plus a config count) and emits one flag word per config slot per
// point of the nest, in row-major order with the last dimension innermost.
module memofs_loop_stage
    import TauCfg::*;
#(
    parameter int unsigned N_CFG  = TauCfg::N_ICFG,
    parameter int unsigned CNT_BW = TauCfg::GLOBAL_ADDR_BW
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           src_rdy,
    output logic                           src_ack,
    input  logic [CNT_BW-1:0]              i_bound [TauCfg::DIM],
    input  logic [$clog2(N_CFG+1)-1:0]     i_ncfg,
    output logic                           dst_rdy,
    input  logic                           dst_ack,
    output logic [0:TauCfg::DIM-1]         o_reset_flag,
    output logic [0:TauCfg::DIM-1]         o_add_flag,
    output logic [$clog2(N_CFG+1)-1:0]     o_id,
    output logic                           o_islast
);

    localparam int unsigned DIM    = TauCfg::DIM;
    localparam int unsigned CFG_BW = $clog2(N_CFG + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;

    logic [CNT_BW-1:0]   bound_q [DIM];
    logic [CNT_BW-1:0]   bound_d [DIM];
    logic [CNT_BW-1:0]   cnt_q   [DIM];
    logic [CNT_BW-1:0]   cnt_d   [DIM];
    logic [CFG_BW-1:0]   ncfg_q, ncfg_d;
    logic [CFG_BW-1:0]   id_q, id_d;
    logic [0:DIM-1]      reset_q, reset_d;
    logic [0:DIM-1]      add_q, add_d;
    logic                islast_q, islast_d;

    logic                cmd_ok;
    logic                cmd_single;
    logic                id_last;

    logic                c_all_last;
    logic [0:DIM-1]      c_add;
    logic [0:DIM-1]      c_reset;
    logic [CNT_BW-1:0]   c_cnt_nxt [DIM];
    logic                c_nxt_all_last;

    NDLoopCarry #(
        .DIM    (DIM),
        .CNT_BW (CNT_BW)
    ) u_carry (
        .bound_i        (bound_q),
        .cnt_i          (cnt_q),
        .all_last_o     (c_all_last),
        .add_flag_o     (c_add),
        .reset_flag_o   (c_reset),
        .cnt_nxt_o      (c_cnt_nxt),
        .nxt_all_last_o (c_nxt_all_last)
    );

    // Commands are only taken while idle; reset masks the acknowledge.
    assign src_ack = src_rdy & (state_q == S_IDLE) & ~i_rst;

    // Command legality and the single-word shortcut for the first islast.
    always_comb begin
        cmd_ok     = (i_ncfg != '0) && (i_ncfg <= CFG_BW'(N_CFG));
        cmd_single = (i_ncfg == CFG_BW'(1));
        for (int k = 0; k < int'(DIM); k++) begin
            if (i_bound[k] == '0) begin
                cmd_ok = 1'b0;
            end
            if (i_bound[k] != CNT_BW'(1)) begin
                cmd_single = 1'b0;
            end
        end
    end

    assign id_last = (id_q == (ncfg_q - CFG_BW'(1)));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (src_ack && cmd_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (dst_ack && islast_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: latch on accept, step id, then carry.
    always_comb begin
        for (int k = 0; k < int'(DIM); k++) begin
            bound_d[k] = bound_q[k];
            cnt_d[k]   = cnt_q[k];
        end
        ncfg_d   = ncfg_q;
        id_d     = id_q;
        reset_d  = reset_q;
        add_d    = add_q;
        islast_d = islast_q;

        unique case (state_q)
            S_IDLE: begin
                if (src_ack && cmd_ok) begin
                    for (int k = 0; k < int'(DIM); k++) begin
                        bound_d[k] = i_bound[k];
                        cnt_d[k]   = '0;
                    end
                    ncfg_d   = i_ncfg;
                    id_d     = '0;
                    reset_d  = '1;
                    add_d    = '0;
                    islast_d = cmd_single;
                end
            end
            S_RUN: begin
                if (dst_ack) begin
                    if (islast_q) begin
                        for (int k = 0; k < int'(DIM); k++) begin
                            cnt_d[k] = '0;
                        end
                        id_d     = '0;
                        reset_d  = '0;
                        add_d    = '0;
                        islast_d = 1'b0;
                    end else if (!id_last) begin
                        id_d     = id_q + CFG_BW'(1);
                        islast_d = c_all_last &&
                                   ((id_q + CFG_BW'(1)) == (ncfg_q - CFG_BW'(1)));
                    end else begin
                        for (int k = 0; k < int'(DIM); k++) begin
                            cnt_d[k] = c_cnt_nxt[k];
                        end
                        id_d     = '0;
                        reset_d  = c_reset;
                        add_d    = c_add;
                        islast_d = c_nxt_all_last && (ncfg_q == CFG_BW'(1));
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < int'(DIM); k++) begin
                bound_q[k] <= '0;
                cnt_q[k]   <= '0;
            end
            ncfg_q   <= '0;
            id_q     <= '0;
            reset_q  <= '0;
            add_q    <= '0;
            islast_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(DIM); k++) begin
                bound_q[k] <= bound_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            ncfg_q   <= ncfg_d;
            id_q     <= id_d;
            reset_q  <= reset_d;
            add_q    <= add_d;
            islast_q <= islast_d;
        end
    end

    assign dst_rdy      = (state_q == S_RUN);
    assign o_reset_flag = reset_q;
    assign o_add_flag   = add_q;
    assign o_id         = id_q;
    assign o_islast     = islast_q;

endmodule : memofs_loop_stage

// File: tb/tb_memofs_loop_stage.sv
// Scoreboard bench for memofs_loop_stage (DIM=3, N_CFG=4, 8-bit bounds).
module tb_memofs_loop_stage;

    typedef struct packed {
        logic [0:2] rst;
        logic [0:2] add;
        logic [2:0] id;
        logic       last;
    } word_t;

    logic       i_clk;
    logic       i_rst;
    logic       src_rdy;
    logic       src_ack;
    logic [7:0] i_bound [3];
    logic [2:0] i_ncfg;
    logic       dst_rdy;
    logic       dst_ack;
    logic [0:2] o_reset_flag;
    logic [0:2] o_add_flag;
    logic [2:0] o_id;
    logic       o_islast;

    word_t      obs;
    word_t      exp_q [$];
    word_t      rec   [$];
    word_t      w_ref;
    int         checks   = 0;
    int         failures = 0;

    memofs_loop_stage #(
        .N_CFG  (4),
        .CNT_BW (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .src_rdy      (src_rdy),
        .src_ack      (src_ack),
        .i_bound      (i_bound),
        .i_ncfg       (i_ncfg),
        .dst_rdy      (dst_rdy),
        .dst_ack      (dst_ack),
        .o_reset_flag (o_reset_flag),
        .o_add_flag   (o_add_flag),
        .o_id         (o_id),
        .o_islast     (o_islast)
    );

    assign obs = word_t'({o_reset_flag, o_add_flag, o_id, o_islast});

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk points by linear index; the advancing dimension is the
    // outermost digit that changed relative to the previous point.
    task automatic push_block(input int b0, input int b1, input int b2, input int nc);
        int    total;
        int    cur [3];
        int    prv [3];
        int    d;
        word_t w;
        total = b0 * b1 * b2;
        prv   = '{0, 0, 0};
        for (int p = 0; p < total; p++) begin
            cur[2] = p % b2;
            cur[1] = (p / b2) % b1;
            cur[0] = p / (b1 * b2);
            w      = '0;
            if (p == 0) begin
                w.rst = 3'b111;
            end else begin
                d = -1;
                for (int k = 0; k < 3; k++) begin
                    if (d < 0 && cur[k] != prv[k]) d = k;
                end
                w.add[d] = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    if (k > d) w.rst[k] = 1'b1;
                end
            end
            for (int c = 0; c < nc; c++) begin
                w.id   = 3'(c);
                w.last = (p == total - 1) && (c == nc - 1);
                exp_q.push_back(w);
            end
            for (int k = 0; k < 3; k++) prv[k] = cur[k];
        end
    endtask

    // Present a command for one cycle (or keep src_rdy up) and check acceptance.
    task automatic start_cmd(input int b0, input int b1, input int b2, input int nc,
                             input bit keep, input bit ok);
        i_bound[0] = 8'(b0);
        i_bound[1] = 8'(b1);
        i_bound[2] = 8'(b2);
        i_ncfg     = 3'(nc);
        src_rdy    = 1'b1;
        #1;
        check("src_ack_idle", 32'(src_ack), 32'(1));
        @(posedge i_clk);
        #1;
        if (!keep) src_rdy = 1'b0;
        check("dst_rdy_rise", 32'(dst_rdy), 32'(ok));
    endtask

    // Drain the scoreboard, optionally stalling at one word or stopping early.
    task automatic consume(input int stall_at, input int abort_after);
        int    idx;
        word_t e;
        idx = 0;
        rec.delete();
        while (exp_q.size() > 0) begin
            check($sformatf("rdy_w%0d", idx), 32'(dst_rdy), 32'(1));
            if (!dst_rdy) begin
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            check($sformatf("word_w%0d", idx), 32'(obs), 32'(e));
            check($sformatf("src_ack_run_w%0d", idx), 32'(src_ack), 32'(0));
            rec.push_back(obs);
            if (idx == stall_at) begin
                repeat (5) begin
                    @(posedge i_clk);
                    #1;
                    check("stall_hold", 32'(obs), 32'(e));
                    check("stall_rdy", 32'(dst_rdy), 32'(1));
                end
            end
            dst_ack = 1'b1;
            @(posedge i_clk);
            #1;
            dst_ack = 1'b0;
            idx++;
            if (idx == abort_after) return;
        end
        check("dst_rdy_fall", 32'(dst_rdy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, b1, b2, nc, st;
        i_clk   = 1'b0;
        i_rst   = 1'b1;
        src_rdy = 1'b1;
        dst_ack = 1'b0;
        i_ncfg  = '0;
        for (int k = 0; k < 3; k++) i_bound[k] = '0;
        #1;
        check("rst_src_ack", 32'(src_ack), 32'(0));
        check("rst_dst_rdy", 32'(dst_rdy), 32'(0));
        check("rst_word", 32'(obs), 32'(0));
        src_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Single-word block.
        push_block(1, 1, 1, 1);
        start_cmd(1, 1, 1, 1, 1'b0, 1'b1);
        consume(-1, 0);
        w_ref = '{rst: 3'b111, add: 3'b000, id: 3'd0, last: 1'b1};
        check("t1_word", 32'(rec[0]), 32'(w_ref));

        // Two configs over a 1x2x3 nest.
        push_block(1, 2, 3, 2);
        start_cmd(1, 2, 3, 2, 1'b0, 1'b1);
        consume(-1, 0);
        check("t2_count", 32'(rec.size()), 32'(12));
        w_ref = '{rst: 3'b000, add: 3'b001, id: 3'd0, last: 1'b0};
        check("t2_w3", 32'(rec[2]), 32'(w_ref));
        w_ref = '{rst: 3'b001, add: 3'b010, id: 3'd0, last: 1'b0};
        check("t2_w7", 32'(rec[6]), 32'(w_ref));
        check("t2_w12_last", 32'(rec[11].last), 32'(1));

        // Backpressure on word 2, then outer-dimension carry.
        push_block(2, 1, 2, 1);
        start_cmd(2, 1, 2, 1, 1'b0, 1'b1);
        consume(1, 0);
        w_ref = '{rst: 3'b011, add: 3'b100, id: 3'd0, last: 1'b0};
        check("t3_w3", 32'(rec[2]), 32'(w_ref));

        // Illegal commands: zero bound, zero config count.
        start_cmd(0, 4, 4, 3, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("zero_bound_idle", 32'(dst_rdy), 32'(0));
        end
        start_cmd(2, 2, 2, 0, 1'b0, 1'b0);
        @(posedge i_clk);
        #1;
        check("zero_ncfg_idle", 32'(dst_rdy), 32'(0));

        // Reset in the middle of a block.
        push_block(2, 2, 2, 1);
        start_cmd(2, 2, 2, 1, 1'b0, 1'b1);
        consume(-1, 3);
        i_rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(dst_rdy), 32'(0));
        check("mid_rst_word", 32'(obs), 32'(0));
        exp_q.delete();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check("post_rst_idle", 32'(dst_rdy), 32'(0));
        end
        push_block(1, 1, 2, 1);
        start_cmd(1, 1, 2, 1, 1'b0, 1'b1);
        consume(-1, 0);
        check("post_rst_count", 32'(rec.size()), 32'(2));

        // Back-to-back with src_rdy held; inputs change while running.
        push_block(1, 2, 2, 2);
        start_cmd(1, 2, 2, 2, 1'b1, 1'b1);
        i_bound[0] = 8'd2;
        i_bound[1] = 8'd1;
        i_bound[2] = 8'd1;
        i_ncfg     = 3'd3;
        consume(-1, 0);
        check("b2b_a_count", 32'(rec.size()), 32'(8));
        check("b2b_src_ack", 32'(src_ack), 32'(1));
        push_block(2, 1, 1, 3);
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
        check("b2b_b_rdy", 32'(dst_rdy), 32'(1));
        consume(-1, 0);
        check("b2b_b_count", 32'(rec.size()), 32'(6));

        // A few random blocks with a random stall point.
        for (int r = 0; r < 4; r++) begin
            b0 = int'($urandom_range(1, 3));
            b1 = int'($urandom_range(1, 3));
            b2 = int'($urandom_range(1, 3));
            nc = int'($urandom_range(1, 4));
            st = int'($urandom_range(0, 5));
            push_block(b0, b1, b2, nc);
            start_cmd(b0, b1, b2, nc, 1'b0, 1'b1);
            consume(st, 0);
            check($sformatf("rand%0d_count", r), 32'(rec.size()), 32'(b0 * b1 * b2 * nc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_memofs_loop_stage
